muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: shift-add MULT and restoring DIV, one pass of the shared adder per cycle.
// Build option MULDIV_SIGNED_EN adds the signed_op port and sign handling around an unsigned core.
module muldiv_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULDIV_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pr_q, pr_d;   // P (multiply) or R (divide)
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] md_q, md_d;   // M (multiply) or D (divide)
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] opa_mag, opb_mag;
  logic [WIDTH-1:0] div_s;
  logic             div_acc;
  logic             last_iter;

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_d;
  logic rneg_q, rneg_d;
  logic isdiv_q, isdiv_d;
  logic a_neg, b_neg;

  // Magnitudes come from dedicated negators; the shared adder is busy only in MUL/DIV.
  assign a_neg   = signed_op & opa[WIDTH-1];
  assign b_neg   = signed_op & opb[WIDTH-1];
  assign opa_mag = a_neg ? -opa : opa;
  assign opb_mag = b_neg ? -opb : opb;
`else
  assign opa_mag = opa;
  assign opb_mag = opb;
`endif

  assign div_s     = {pr_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign div_acc   = add_cout | pr_q[WIDTH-1];
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    q_d     = q_q;
    md_d    = md_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    isdiv_d = isdiv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pr_d  = '0;
          q_d   = opa_mag;
          md_d  = opb_mag;
          cnt_d = '0;
`ifdef MULDIV_SIGNED_EN
          isdiv_d = op;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
`endif
          if (!op) begin
            state_d = S_MUL;
          end else if (opb == '0) begin
            // Divide by zero skips iteration; raw dividend becomes the remainder.
            state_d = S_DONE;
            pr_d    = opa;
            q_d     = '1;
`ifdef MULDIV_SIGNED_EN
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
`endif
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        add_a   = pr_q;
        add_b   = q_q[0] ? md_q : '0;
        pr_d    = {add_cout, add_sum[WIDTH-1:1]};
        q_d     = {add_sum[0], q_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_iter) state_d = S_DONE;
      end
      S_DIV: begin
        add_a   = div_s;
        add_b   = md_q;
        add_sub = 1'b1;
        pr_d    = div_acc ? add_sum : div_s;
        q_d     = {q_q[WIDTH-2:0], div_acc};
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef MULDIV_SIGNED_EN
        if (isdiv_q) begin
          lo_d = neg_q ? -q_q : q_q;
          hi_d = rneg_q ? -pr_q : pr_q;
        end else begin
          {hi_d, lo_d} = neg_q ? -{pr_q, q_q} : {pr_q, q_q};
        end
`else
        hi_d = pr_q;
        lo_d = q_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      q_q     <= '0;
      md_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      isdiv_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      q_q     <= q_d;
      md_q    <= md_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULDIV_SIGNED_EN
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      isdiv_q <= isdiv_d;
`endif
    end
  end

  assign add_cin = add_sub;
  assign busy    = (state_q == S_MUL) || (state_q == S_DIV);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model, per-cycle output compare and directed vectors.
// Signed vectors are exercised when MULDIV_SIGNED_EN is defined.
module tb_muldiv_sequencer;
  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic [W-1:0] add_a, add_b, add_sum, hi, lo;
  logic         add_sub, add_cin, add_cout, busy, done;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  // Shared ripple adder/subtractor: B is inverted when add_sub is high.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)} + {{W{1'b0}}, add_cin};

  muldiv_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
`ifdef MULDIV_SIGNED_EN
    .signed_op(sgn),
`endif
    .opa      (opa),
    .opb      (opb),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sub  (add_sub),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  // Reference results by plain integer arithmetic: returns {hi, lo}.
  function automatic logic [2*W-1:0] model_result(input logic o, input logic s,
                                                  input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, t, qq, rr;
    logic [2*W-1:0] r;
    sa = (s && a[W-1]) ? longint'(a) - (longint'(1) << W) : longint'(a);
    sb = (s && b[W-1]) ? longint'(b) - (longint'(1) << W) : longint'(b);
    if (o && b == '0) begin
      r = {a, {W{1'b1}}};
    end else if (!o) begin
      t = sa * sb;
      r = t[2*W-1:0];
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      r = {rr[W-1:0], qq[W-1:0]};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_mag(input logic s, input logic [W-1:0] b);
    return (s && b[W-1]) ? -b : b;
  endfunction

  // Model timeline: accept at edge acc_e, busy for W cycles, results and done after edge fin_e.
  longint       cyc = 0;
  longint       acc_e = -100;
  longint       fin_e = -100;
  logic         m_div = 1'b0;
  logic         m_div0 = 1'b0;
  logic [W-1:0] m_b = '0;
  logic [W-1:0] pend_hi = '0, pend_lo = '0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      acc_e  <= -100;
      fin_e  <= -100;
      exp_hi <= '0;
      exp_lo <= '0;
    end else begin
      if (cyc + 1 == fin_e) begin
        exp_hi <= pend_hi;
        exp_lo <= pend_lo;
      end
      if (start && (cyc + 1 > fin_e)) begin
        {pend_hi, pend_lo} <= model_result(op, sgn, opa, opb);
        m_b    <= model_mag(sgn, opb);
        m_div  <= op;
        m_div0 <= op && (opb == '0);
        acc_e  <= cyc + 1;
        fin_e  <= cyc + 1 + ((op && opb == '0) ? 1 : W + 1);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    logic bx;
    @(negedge clk);
    if (chk_en) begin
      bx = !m_div0 && (cyc >= acc_e) && (cyc <= acc_e + W - 1);
      chk("busy", busy, bx);
      chk("done", done, cyc == fin_e);
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
      chk("add_sub", add_sub, bx && m_div);
      chk("add_cin", add_cin, bx && m_div);
      if (!bx) begin
        chk("add_a_idle", add_a, 0);
        chk("add_b_idle", add_b, 0);
      end else if (m_div) begin
        chk("add_b_div", add_b, m_b);
      end else begin
        chk("add_b_mul", (add_b == '0) || (add_b == m_b), 1);
      end
    end
  endtask

  task automatic run_op(input string nm, input logic o, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input int elat, input int ebusy, input logic pulse);
    int lat, bc;
    start = 1'b1; op = o; sgn = s; opa = a; opb = b;
    tick();
    start = 1'b0;
    opa = ~a;
    opb = ~b;
    lat = 1;
    bc = busy ? 1 : 0;
    while (!done && lat < 40) begin
      start = pulse && (lat == 3 || lat == 5);
      if (start) begin
        op  = 1'b1;
        opb = '0;
      end
      tick();
      lat++;
      if (busy) bc++;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_busy_cycles"}, bc, ebusy);
    chk({nm, "_hi"}, hi, ehi);
    chk({nm, "_lo"}, lo, elo);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_sub", add_sub, 0);
    chk("rst_add_cin", add_cin, 0);
    reset = 1'b0;
    tick();

    run_op("mul13x11", 1'b0, 1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 10, 8, 1'b0);
    run_op("mulFFxFF", 1'b0, 1'b0, 8'hFF,  8'hFF,  8'hFE, 8'h01, 10, 8, 1'b0);
    run_op("mul0x37",  1'b0, 1'b0, 8'h00,  8'h37,  8'h00, 8'h00, 10, 8, 1'b0);
    run_op("mul80x02", 1'b0, 1'b0, 8'h80,  8'h02,  8'h01, 8'h00, 10, 8, 1'b0);
    run_op("div200_7", 1'b1, 1'b0, 8'd200, 8'd7,   8'h04, 8'h1C, 10, 8, 1'b0);
    run_op("div80_01", 1'b1, 1'b0, 8'h80,  8'h01,  8'h00, 8'h80, 10, 8, 1'b0);
    run_op("divFF_10", 1'b1, 1'b0, 8'hFF,  8'h10,  8'h0F, 8'h0F, 10, 8, 1'b0);
    run_op("div0",     1'b1, 1'b0, 8'h55,  8'h00,  8'h55, 8'hFF, 2,  0, 1'b0);
    run_op("ign_start",1'b0, 1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 10, 8, 1'b1);

    // Abort a multiply with reset in its fourth cycle.
    start = 1'b1; op = 1'b0; sgn = 1'b0; opa = 8'hFF; opb = 8'hFF;
    tick();
    start = 1'b0;
    lat = 1;
    while (lat < 4) begin
      tick();
      lat++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    run_op("mul3x3",   1'b0, 1'b0, 8'd3,   8'd3,   8'h00, 8'h09, 10, 8, 1'b0);

`ifdef MULDIV_SIGNED_EN
    run_op("smulm6x7", 1'b0, 1'b1, 8'hFA,  8'h07,  8'hFF, 8'hD6, 10, 8, 1'b0);
    run_op("sdivm7_2", 1'b1, 1'b1, 8'hF9,  8'h02,  8'hFF, 8'hFD, 10, 8, 1'b0);
    run_op("umulFAx7", 1'b0, 1'b0, 8'hFA,  8'h07,  8'h06, 8'hD6, 10, 8, 1'b0);
    run_op("sdiv0",    1'b1, 1'b1, 8'hF9,  8'h00,  8'hF9, 8'hFF, 2,  0, 1'b0);
`endif

    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
